// File: rtl/dig_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dig_mod_pkg
//  Description : Shared definitions for the digital modulator core: modulation
//                mode encodings and maximal-length LFSR tap masks, orders 3..16.
//  Revision    : 1.0 - initial release
// ============================================================================
package dig_mod_pkg;

  typedef enum logic [1:0] {
    MODE_CARRIER = 2'd0,
    MODE_ASK     = 2'd1,
    MODE_FSK     = 2'd2,
    MODE_BPSK    = 2'd3
  } mode_e;

  // Tap masks: bit i set means stage i+1 feeds back (maximal-length polynomials)
  localparam logic [15:0] TAPS_N3  = 16'h0006;
  localparam logic [15:0] TAPS_N4  = 16'h000C;
  localparam logic [15:0] TAPS_N5  = 16'h0014;
  localparam logic [15:0] TAPS_N6  = 16'h0030;
  localparam logic [15:0] TAPS_N7  = 16'h0060;
  localparam logic [15:0] TAPS_N8  = 16'h00B8;
  localparam logic [15:0] TAPS_N9  = 16'h0110;
  localparam logic [15:0] TAPS_N10 = 16'h0240;
  localparam logic [15:0] TAPS_N11 = 16'h0500;
  localparam logic [15:0] TAPS_N12 = 16'h0829;
  localparam logic [15:0] TAPS_N13 = 16'h100D;
  localparam logic [15:0] TAPS_N14 = 16'h2015;
  localparam logic [15:0] TAPS_N15 = 16'h6000;
  localparam logic [15:0] TAPS_N16 = 16'hD008;

  // Look up the default tap mask for a given LFSR order (zero if unsupported)
  function automatic logic [15:0] default_taps(input int n);
    case (n)
      3:       default_taps = TAPS_N3;
      4:       default_taps = TAPS_N4;
      5:       default_taps = TAPS_N5;
      6:       default_taps = TAPS_N6;
      7:       default_taps = TAPS_N7;
      8:       default_taps = TAPS_N8;
      9:       default_taps = TAPS_N9;
      10:      default_taps = TAPS_N10;
      11:      default_taps = TAPS_N11;
      12:      default_taps = TAPS_N12;
      13:      default_taps = TAPS_N13;
      14:      default_taps = TAPS_N14;
      15:      default_taps = TAPS_N15;
      16:      default_taps = TAPS_N16;
      default: default_taps = 16'h0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pn_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : pn_lfsr
//  Description : Fibonacci PN LFSR. Shifts left on step, feedback (XOR of the
//                tapped stages) enters at the LSB. An all-zero state is forced
//                back to all ones on the next clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module pn_lfsr
  import dig_mod_pkg::*;
#(
  parameter int                LFSR_N    = 7,
  parameter logic [LFSR_N-1:0] LFSR_TAPS = 7'h60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [LFSR_N-1:0] state
);

  logic w_fb;

  // Feedback bit from the tapped stages
  always_comb begin
    w_fb = ^(state & LFSR_TAPS);
  end

  // State register with lock-up recovery
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '1;
    end else if (state == '0) begin
      state <= '1;
    end else if (step) begin
      state <= {state[LFSR_N-2:0], w_fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/dig_mod_core.sv
`default_nettype none
// ============================================================================
//  Module      : dig_mod_core
//  Description : Digital modulator core: DDS phase accumulator, symbol timer,
//                PN symbol source and carrier/ASK/FSK/BPSK mode logic driving
//                an external sine ROM address and a ROM-aligned amplitude gate.
//                Configuration is double-buffered and applied at symbol wraps.
//                Optional: define DIG_MOD_PHASE_SYNC_EN to clear the phase
//                accumulator on every symbol wrap (coherent symbol start).
//  Revision    : 1.0 - initial release
// ============================================================================
module dig_mod_core
  import dig_mod_pkg::*;
#(
  parameter int                ACC_W     = 32,
  parameter int                ADDR_W    = 12,
  parameter int                SYM_DIV_W = 16,
  parameter int                LFSR_N    = 7,
  parameter logic [LFSR_N-1:0] LFSR_TAPS = 7'h60,
  parameter int                ROM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [1:0]           cfg_mode,
  input  logic [ACC_W-1:0]     cfg_fcw0,
  input  logic [ACC_W-1:0]     cfg_fcw1,
  input  logic [SYM_DIV_W-1:0] cfg_div,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic                 amp_gate,
  output logic                 sym_bit,
  output logic                 sym_strobe
);

  localparam logic [SYM_DIV_W-1:0] c_cnt_one = {{(SYM_DIV_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]    c_half    = {1'b1, {(ADDR_W-1){1'b0}}};

  // Active and shadow configuration
  mode_e                r_mode_act, r_mode_sh;
  logic [ACC_W-1:0]     r_fcw0_act, r_fcw1_act, r_fcw0_sh, r_fcw1_sh;
  logic [SYM_DIV_W-1:0] r_div_act, r_div_sh;
  logic                 r_pending;

  logic [SYM_DIV_W-1:0] r_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_gate;

  logic                 w_wrap;
  logic [ACC_W-1:0]     w_fsel;
  logic [ADDR_W-1:0]    w_poff;
  logic                 w_gate;
  logic                 w_msb_next;
  logic [LFSR_N-1:0]    w_lfsr_state;

  pn_lfsr #(
    .LFSR_N    (LFSR_N),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_pn_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (w_wrap),
    .state (w_lfsr_state)
  );

  // Symbol wrap, frequency/phase selection and gate decision from active config
  always_comb begin
    w_wrap     = (r_cnt == r_div_act);
    w_fsel     = (r_mode_act == MODE_FSK && sym_bit) ? r_fcw1_act : r_fcw0_act;
    w_poff     = (r_mode_act == MODE_BPSK && sym_bit) ? c_half : '0;
    w_gate     = (r_mode_act == MODE_ASK) ? sym_bit : 1'b1;
    // MSB the LFSR will hold after this step (an all-zero state recovers to all ones)
    w_msb_next = (w_lfsr_state == '0) ? 1'b1 : w_lfsr_state[LFSR_N-2];
  end

  // Shadow capture and wrap-time transfer into the active configuration
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode_act <= MODE_CARRIER;
      r_fcw0_act <= '0;
      r_fcw1_act <= '0;
      r_div_act  <= '1;
      r_mode_sh  <= MODE_CARRIER;
      r_fcw0_sh  <= '0;
      r_fcw1_sh  <= '0;
      r_div_sh   <= '1;
      r_pending  <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_mode_act <= r_mode_sh;
        r_fcw0_act <= r_fcw0_sh;
        r_fcw1_act <= r_fcw1_sh;
        r_div_act  <= r_div_sh;
      end
      // A load on the wrap cycle keeps pending set so the new values land next wrap
      if (cfg_load) begin
        r_mode_sh <= mode_e'(cfg_mode);
        r_fcw0_sh <= cfg_fcw0;
        r_fcw1_sh <= cfg_fcw1;
        r_div_sh  <= cfg_div;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Symbol timer, strobe and current symbol bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      sym_strobe <= 1'b0;
      sym_bit    <= 1'b0;
    end else begin
      sym_strobe <= w_wrap;
      if (w_wrap) begin
        r_cnt   <= '0;
        sym_bit <= w_msb_next;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  // Phase accumulator, ROM address and gate stage aligned with the address
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc    <= '0;
      rom_addr <= '0;
      r_gate   <= 1'b0;
    end else begin
`ifdef DIG_MOD_PHASE_SYNC_EN
      r_acc <= w_wrap ? '0 : r_acc + w_fsel;
`else
      r_acc <= r_acc + w_fsel;
`endif
      rom_addr <= r_acc[ACC_W-1 -: ADDR_W] + w_poff;
      r_gate   <= w_gate;
    end
  end

  // Delay the gate by the ROM read latency so it lines up with ROM data
  generate
    if (ROM_LAT == 1) begin : g_lat_one
      logic r_dly;
      // Single-stage gate delay
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_dly <= 1'b0;
        end else begin
          r_dly <= r_gate;
        end
      end
      assign amp_gate = r_dly;
    end else begin : g_lat_multi
      logic [ROM_LAT-1:0] r_dly;
      // Multi-stage gate delay line
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_dly <= '0;
        end else begin
          r_dly <= {r_dly[ROM_LAT-2:0], r_gate};
        end
      end
      assign amp_gate = r_dly[ROM_LAT-1];
    end
  endgenerate

endmodule
`default_nettype wire
